// File: rtl/rfifo_out_stage_if.sv
// Handshake bundle between the async FIFO read side, the output stage and the downstream consumer.
// The master modport is the output stage; the slave modport is its environment.
interface rfifo_out_stage_if #(
    parameter int DataWidth = 8
);
    logic                 rempty_i;
    logic                 rinc_o;
    logic [DataWidth-1:0] rdata_i;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [DataWidth-1:0] m_data_o;

    modport master (
        input  rempty_i,
        input  rdata_i,
        input  m_ready_i,
        output rinc_o,
        output m_valid_o,
        output m_data_o
    );

    modport slave (
        output rempty_i,
        output rdata_i,
        output m_ready_i,
        input  rinc_o,
        input  m_valid_o,
        input  m_data_o
    );
endinterface

// File: rtl/rfifo_out_stage.sv
// Read-domain output stage: converts the FIFO rempty/rinc/rdata interface into a registered
// valid/ready stream through a 2-entry head/skid buffer, with no path from m_ready_i to rinc_o.
module rfifo_out_stage #(
    parameter int DataWidth = 8
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                flush_i,
    output logic [1:0]          occ_o,
    rfifo_out_stage_if.master   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e                 r_occ;
    logic [DataWidth-1:0] r_head;
    logic [DataWidth-1:0] r_skid;

    logic w_push;
    logic w_pop;

    // Pops only while a slot is free; depends on registered occupancy, never on m_ready_i.
    assign w_push = !bus.rempty_i && (r_occ == EMPTY || r_occ == ONE) && !flush_i && !rrst;
    assign w_pop  = bus.m_valid_o && bus.m_ready_i;

    assign bus.rinc_o    = w_push;
    assign bus.m_valid_o = (r_occ == ONE) || (r_occ == TWO);
    assign bus.m_data_o  = r_head;
    assign occ_o         = r_occ;

    // NOTE: every register in this block uses <= so all next-state terms read pre-edge values.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_occ  <= EMPTY;
            r_head <= '0;
            r_skid <= '0;
        end else if (flush_i) begin
            r_occ <= EMPTY;
        end else begin
            case (r_occ)
                EMPTY: begin
                    if (w_push) begin
                        r_head <= bus.rdata_i;
                        r_occ  <= ONE;
                    end
                end
                ONE: begin
                    case ({w_push, w_pop})
                        2'b11: r_head <= bus.rdata_i;
                        2'b10: begin
                            r_skid <= bus.rdata_i;
                            r_occ  <= TWO;
                        end
                        2'b01: r_occ <= EMPTY;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (w_pop) begin
                        r_head <= r_skid;
                        r_occ  <= ONE;
                    end
                end
                // Encoding 3 is unreachable; recover to an empty buffer.
                default: r_occ <= EMPTY;
            endcase
        end
    end

endmodule
